op_select_updown: RTL

- Bidirectional operation-select counter for the Simple Calculator.
- Two pushbuttons step the mux select code: one steps up, the other steps down.
- Each button is synchronized, debounced and edge-detected inside the block.
- Drives the same WIDTH-bit select bus the operation muxes consume. Emits a one-cycle step strobe and the last step direction for display logic.

---
 rtl/op_select_updown.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/op_select_updown.sv
// op_select_updown: operation-select code stepped up/down by two debounced pushbuttons.
// Build option OP_SELECT_AUTO_REPEAT_EN adds auto-repeat stepping while one button is held.

module op_select_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_raw,
  output logic stable_r,
  output logic rise_s
);

  localparam int CW = (DB_CYCLES < 32'sd2) ? 32'sd1 : $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 32'sd1);

  logic          sync_meta_r;
  logic          sync_r;
  logic          stable_d_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          stable_nxt_s;

  // Two-flop synchronizer on the raw button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      sync_meta_r <= pb_raw;
      sync_r      <= sync_meta_r;
    end
  end

  // Count consecutive cycles the synchronized level disagrees with the accepted one.
  always_comb begin
    cnt_nxt_s    = CNT_ZERO;
    stable_nxt_s = stable_r;
    if (sync_r != stable_r) begin
      if (cnt_r == CNT_LAST) begin
        cnt_nxt_s    = CNT_ZERO;
        stable_nxt_s = sync_r;
      end else begin
        cnt_nxt_s    = cnt_r + CNT_ONE;
        stable_nxt_s = stable_r;
      end
    end else begin
      cnt_nxt_s    = CNT_ZERO;
      stable_nxt_s = stable_r;
    end
  end

  // Debounce state plus the delayed copy used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= CNT_ZERO;
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      stable_r   <= stable_nxt_s;
      stable_d_r <= stable_r;
    end
  end

  // Rising edge of the accepted level; releases never produce a rise.
  always_comb begin
    rise_s = stable_r & ~stable_d_r;
  end

endmodule

module op_select_updown #(
  parameter int WIDTH        = 2,
  parameter int DB_CYCLES    = 50000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pb_up_in,
  input  logic             pb_down_in,
  output logic [WIDTH-1:0] sel,
  output logic             step_pulse,
  output logic             dir
);

  localparam logic [WIDTH-1:0] SEL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] SEL_ONE  = WIDTH'(32'd1);

  logic             stable_up_r;
  logic             stable_down_r;
  logic             rise_up_s;
  logic             rise_down_s;
  logic             rise_up_only_s;
  logic             rise_down_only_s;
  logic             any_rise_s;
  logic             repeat_up_s;
  logic             repeat_down_s;
  logic             step_up_s;
  logic             step_down_s;
  logic [WIDTH-1:0] sel_nxt_s;
  logic             dir_nxt_s;

  // Empty scope that only elaborates for out-of-range parameter sets.
  if (WIDTH < 32'sd1 || DB_CYCLES < 32'sd1 || REPEAT_DELAY < 32'sd1 || REPEAT_RATE < 32'sd1) begin : g_param_range_violation
  end

  op_select_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_up (
    .clk      (clk),
    .rst      (rst),
    .pb_raw   (pb_up_in),
    .stable_r (stable_up_r),
    .rise_s   (rise_up_s)
  );

  op_select_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_down (
    .clk      (clk),
    .rst      (rst),
    .pb_raw   (pb_down_in),
    .stable_r (stable_down_r),
    .rise_s   (rise_down_s)
  );

  // Simultaneous rises cancel each other.
  always_comb begin
    rise_up_only_s   = rise_up_s & ~rise_down_s;
    rise_down_only_s = rise_down_s & ~rise_up_s;
    any_rise_s       = rise_up_s | rise_down_s;
  end

`ifdef OP_SELECT_AUTO_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW       = (HOLD_MAX < 32'sd2) ? 32'sd1 : $clog2(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_ZERO  = {HW{1'b0}};
  localparam logic [HW-1:0] HOLD_ONE   = HW'(32'd1);
  localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 32'sd1);
  localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 32'sd1);

  logic [HW-1:0] hold_cnt_r;
  logic [HW-1:0] hold_cnt_nxt_s;
  logic [HW-1:0] hold_last_s;
  logic          repeating_r;
  logic          repeating_nxt_s;
  logic          held_one_s;
  logic          repeat_fire_s;

  // Hold timer: first repeat after REPEAT_DELAY, later ones every REPEAT_RATE.
  always_comb begin
    held_one_s      = stable_up_r ^ stable_down_r;
    hold_last_s     = repeating_r ? RATE_LAST : DELAY_LAST;
    repeat_fire_s   = held_one_s & (hold_cnt_r == hold_last_s);
    repeat_up_s     = repeat_fire_s & stable_up_r;
    repeat_down_s   = repeat_fire_s & stable_down_r;
    hold_cnt_nxt_s  = HOLD_ZERO;
    repeating_nxt_s = 1'b0;
    if (rise_up_only_s | rise_down_only_s) begin
      hold_cnt_nxt_s  = HOLD_ZERO;
      repeating_nxt_s = 1'b0;
    end else if (!held_one_s) begin
      hold_cnt_nxt_s  = HOLD_ZERO;
      repeating_nxt_s = 1'b0;
    end else if (repeat_fire_s) begin
      hold_cnt_nxt_s  = HOLD_ZERO;
      repeating_nxt_s = 1'b1;
    end else begin
      hold_cnt_nxt_s  = hold_cnt_r + HOLD_ONE;
      repeating_nxt_s = repeating_r;
    end
  end

  // Hold timer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_r  <= HOLD_ZERO;
      repeating_r <= 1'b0;
    end else begin
      hold_cnt_r  <= hold_cnt_nxt_s;
      repeating_r <= repeating_nxt_s;
    end
  end
`else
  // Without auto-repeat only a fresh press steps the select code.
  always_comb begin
    repeat_up_s   = 1'b0;
    repeat_down_s = 1'b0;
  end
`endif

  // Resolve this cycle's step; a press always takes precedence over a repeat.
  always_comb begin
    step_up_s   = rise_up_only_s | (~any_rise_s & repeat_up_s);
    step_down_s = rise_down_only_s | (~any_rise_s & repeat_down_s);
    sel_nxt_s   = sel;
    dir_nxt_s   = dir;
    if (step_up_s) begin
      sel_nxt_s = sel + SEL_ONE;
      dir_nxt_s = 1'b1;
    end else if (step_down_s) begin
      sel_nxt_s = sel - SEL_ONE;
      dir_nxt_s = 1'b0;
    end else begin
      sel_nxt_s = sel;
      dir_nxt_s = dir;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= SEL_ZERO;
      step_pulse <= 1'b0;
      dir        <= 1'b0;
    end else begin
      sel        <= sel_nxt_s;
      step_pulse <= step_up_s | step_down_s;
      dir        <= dir_nxt_s;
    end
  end

endmodule
